axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3-style slave responder: the target end of the AXI link that our CPU-side SRAM/cache-to-AXI bridge drives as master.
- Accepts read and write bursts and services them against a single-port synchronous SRAM with 1-cycle read latency.
- Serves as the memory endpoint in simulation and in the FPGA top level.
- Serves one transaction at a time, with no outstanding-transaction overlap.

Parameters:
- ADDR_W, 16, SRAM word-address width; ram_addr = byte_addr[ADDR_W+1:2].
- LFSR_SEED, 8'hA5, initial value of the stall LFSR (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- AR channel: arid in 4; araddr in 32; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
- R channel: rid out 4; rdata out 32; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
- AW channel: awid in 4; awaddr in 32; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
- W channel: wid in 4 (ignored); wdata in 32; wstrb in 4; wlast in 1; wvalid in 1; wready out 1.
- B channel: bid out 4; bresp out 2; bvalid out 1; bready in 1.
- SRAM: ram_en out 1; ram_we out 4; ram_addr out ADDR_W; ram_wdata out 32; ram_rdata in 32 (valid the cycle after ram_en with ram_we=0).

Behaviour:
- Reset (applies mid-transaction too, aborting it with no R/B response):
  - state=IDLE.
  - All ready/valid outputs 0; rlast 0.
  - rid/bid/rresp/bresp 0; rdata 0.
  - ram_en/ram_we 0; beat counter 0.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_SEND, WR_DATA, WR_RESP.
- IDLE:
  - awready=1.
  - arready = ~awvalid; a write wins when both are valid.
  - On AW handshake: latch id/addr/len/size/burst, go to WR_DATA.
  - On AR handshake: latch the same fields, go to RD_ISSUE.
- Burst decode:
  - FIXED (00): address held.
  - INCR (01): address += (1<<size) per beat, wrapping modulo 2^32; ram_addr wraps modulo 2^ADDR_W.
  - WRAP/reserved (1x): no SRAM writes; reads return rdata=0; response SLVERR (2'b10) on every R beat and on B.
  - Otherwise the response is OKAY (00).
- RD_ISSUE: ram_en=1, ram_we=0, ram_addr=current address. Go to RD_WAIT.
- RD_WAIT: register ram_rdata into rdata. Go to RD_SEND.
- RD_SEND:
  - rvalid=1; rid=latched id; rlast = (beat_cnt==len).
  - rdata/rresp/rlast are held stable while rready=0.
  - On handshake: last beat goes to IDLE; otherwise beat_cnt+1, advance the address, go to RD_ISSUE.
- Read latency: AR handshake at cycle T gives the first rvalid at T+3; each further beat follows 3 cycles after the prior handshake.
- WR_DATA:
  - wready=1.
  - On W handshake, in the same cycle: ram_en=1, ram_we=wstrb (forced 0 for a bad burst), ram_wdata=wdata, ram_addr=current address.
  - Then advance the address and beat_cnt.
  - Burst termination is decided by wlast only. If beat_cnt != len on the wlast beat, bresp=SLVERR; the beats are still written.
  - After wlast go to WR_RESP.
- WR_RESP: bvalid=1, bid=latched id, bresp held until bready; then go to IDLE.
- No ready is asserted outside its state, and no valid drops before its handshake.
- A read issued after a write handshake observes the written data (there is no overlap).

Optional Feature:
- Macro AXI_SLV_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seeded LFSR_SEED on reset) advances every cycle.
  - When lfsr[0]=1, arready, awready and wready are forced 0 that cycle.
  - rvalid assertion on RD_SEND entry is deferred until a cycle with lfsr[0]=0. Once asserted, rvalid holds until the handshake.
- When undefined: no stalls; the latencies above are exact.

Test Plan:
- Single write then read: AW addr 0x100, len 0, wdata 0xDEADBEEF, wstrb 4'hF; then AR 0x100. Required: bresp 00, bid echoed; rdata 0xDEADBEEF with rlast=1; rvalid at T+3.
- INCR burst: write len 3 at 0x200 with data 1,2,3,4; read len 3. Required: four R beats 1,2,3,4; rlast only on beat 4; ram_addr 0x80..0x83.
- Partial strobe: memory holds 0xFFFFFFFF, write 0x12345678 with wstrb 4'b0101. Required: read returns 0xFF34FF78.
- Error cases:
  - awburst=2'b10: bresp 10 and SRAM unchanged.
  - wlast on beat 2 of a len-3 burst: bresp 10.
  - arburst=2'b11: rresp 10 and rdata 0.
- Contention, backpressure and reset:
  - arvalid and awvalid in the same cycle: AW accepted first.
  - rready held low 5 cycles: rdata stable.
  - areset mid-burst: all valids 0 the next cycle and FSM in IDLE.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI3 read/write channel bundle between bridge master and SRAM slave
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-transaction AXI3 slave over a 1-cycle-latency SRAM
// Define AXI_SLV_STALL_EN to add LFSR-driven ready stalls and deferred rvalid.
module axi_sram_slave #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              aclk,
    input  logic              areset,
    axi_sram_slave_if.slave   axi,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_SEND, WR_DATA, WR_RESP} state_t;
    state_t      state;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  beat_cnt;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  lfsr;
    logic        stall;
    logic        bad;
    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        r_hs;
    logic        b_hs;
    logic [31:0] next_addr;

    always_ff @(posedge aclk)
        lfsr <= areset ? LFSR_SEED : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

`ifdef AXI_SLV_STALL_EN
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // WRAP and the reserved encoding share burst[1]=1 and are both rejected
    assign bad       = burst[1];
    assign next_addr = burst == 2'b01 ? addr + (32'd1 << size) : addr;

    assign axi.awready = state == IDLE && !areset && !stall;
    assign axi.arready = state == IDLE && !areset && !stall && !axi.awvalid;
    assign axi.wready  = state == WR_DATA && !areset && !stall;

    assign aw_hs = axi.awvalid && axi.awready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign r_hs  = axi.rvalid && axi.rready;
    assign b_hs  = axi.bvalid && axi.bready;

    assign ram_en    = state == RD_ISSUE || w_hs;
    assign ram_we    = w_hs && !bad ? axi.wstrb : 4'd0;
    assign ram_addr  = addr[ADDR_W+1:2];
    assign ram_wdata = axi.wdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            id         <= '0;
            addr       <= '0;
            len        <= '0;
            size       <= '0;
            burst      <= '0;
            beat_cnt   <= '0;
            axi.rvalid <= 1'b0;
            axi.rid    <= '0;
            axi.rdata  <= '0;
            axi.rresp  <= '0;
            axi.rlast  <= 1'b0;
            axi.bvalid <= 1'b0;
            axi.bid    <= '0;
            axi.bresp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs || ar_hs) begin
                        id       <= aw_hs ? axi.awid    : axi.arid;
                        addr     <= aw_hs ? axi.awaddr  : axi.araddr;
                        len      <= aw_hs ? axi.awlen   : axi.arlen;
                        size     <= aw_hs ? axi.awsize  : axi.arsize;
                        burst    <= aw_hs ? axi.awburst : axi.arburst;
                        beat_cnt <= '0;
                        state    <= aw_hs ? WR_DATA : RD_ISSUE;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    axi.rdata  <= bad ? 32'd0 : ram_rdata;
                    axi.rresp  <= bad ? 2'b10 : 2'b00;
                    axi.rlast  <= beat_cnt == len;
                    axi.rid    <= id;
                    axi.rvalid <= !stall;
                    state      <= RD_SEND;
                end
                RD_SEND: begin
                    if (r_hs) begin
                        axi.rvalid <= 1'b0;
                        beat_cnt   <= beat_cnt + 8'd1;
                        addr       <= next_addr;
                        state      <= axi.rlast ? IDLE : RD_ISSUE;
                    end else if (!stall) begin
                        axi.rvalid <= 1'b1;
                    end
                end
                WR_DATA: begin
                    // wlast alone ends the burst; a length mismatch only taints bresp
                    if (w_hs) begin
                        addr     <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (axi.wlast) begin
                            axi.bvalid <= 1'b1;
                            axi.bid    <= id;
                            axi.bresp  <= bad || beat_cnt != len ? 2'b10 : 2'b00;
                            state      <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        axi.bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed vector table plus hand sequences against a behavioural SRAM
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:65535];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axi_sram_slave_if axi();

    axi_sram_slave dut (
        .aclk(clk), .areset(rst), .axi(axi),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_we == 4'd0) ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] d0;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp0;
        bit          inc;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi.awid = id; axi.awaddr = a; axi.awlen = len; axi.awsize = 3'd2; axi.awburst = burst; axi.awvalid = 1'b1;
        #1;
        while (!axi.awready && n < 50) begin step(); n++; end
        if (n >= 50) chk("aw_timeout", 32'(n), 32'd0);
        step();
        axi.awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arsize = 3'd2; axi.arburst = burst; axi.arvalid = 1'b1;
        #1;
        while (!axi.arready && n < 50) begin step(); n++; end
        if (n >= 50) chk("ar_timeout", 32'(n), 32'd0);
        step();
        axi.arvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] a, input logic [1:0] burst, input logic [31:0] d0,
                           input logic [3:0] strb, input int last_idx);
        logic [31:0] ea;
        for (int k = 0; k <= last_idx; k++) begin
            int n = 0;
            axi.wdata = d0 + 32'(k); axi.wstrb = strb; axi.wlast = k == last_idx; axi.wvalid = 1'b1;
            #1;
            while (!axi.wready && n < 50) begin step(); n++; end
            if (n >= 50) chk("w_timeout", 32'(n), 32'd0);
            ea = burst == 2'b01 ? a + 32'(4 * k) : a;
            chk("w_ram_en", 32'(ram_en), 32'd1);
            chk("w_ram_addr", 32'(ram_addr), 32'(ea[17:2]));
            chk("w_ram_we", 32'(ram_we), burst[1] ? 32'd0 : 32'(strb));
            step();
        end
        axi.wvalid = 1'b0;
        axi.wlast = 1'b0;
    endtask

    task automatic b_wait(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        axi.bready = 1'b1;
        #1;
        while (!axi.bvalid && n < 50) begin step(); n++; end
        if (n >= 50) chk("b_timeout", 32'(n), 32'd0);
        resp = axi.bresp;
        id = axi.bid;
        step();
        chk("b_drop", 32'(axi.bvalid), 32'd0);
    endtask

    // handshake edge is already behind us; rvalid must appear two edges later
    task automatic read_beats(input string tag, input logic [3:0] id, input logic [7:0] len,
                              input logic [31:0] exp0, input bit inc, input logic [1:0] resp);
        axi.rready = 1'b1;
        for (int k = 0; k <= int'(len); k++) begin
            int n = 0;
            do begin step(); n++; end while (!axi.rvalid && n < 20);
            chk({tag, "_latency"}, 32'(n), 32'd2);
            chk({tag, "_rdata"}, axi.rdata, exp0 + (inc ? 32'(k) : 32'd0));
            chk({tag, "_rresp"}, 32'(axi.rresp), 32'(resp));
            chk({tag, "_rlast"}, 32'(axi.rlast), 32'(k == int'(len)));
            chk({tag, "_rid"}, 32'(axi.rid), 32'(id));
            step();
        end
        chk({tag, "_rdrop"}, 32'(axi.rvalid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br;
        logic [3:0]  bi;
        logic [31:0] held;
        int          n;
        tbl[0]  = '{1'b1, 4'd3,  32'h0000_0100, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'hF,    2'b00, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 4'd5,  32'h0000_0100, 8'd0, 2'b01, 32'h0,         4'h0,    2'b00, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 4'd1,  32'h0000_0200, 8'd3, 2'b01, 32'h1,         4'hF,    2'b00, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 4'd2,  32'h0000_0200, 8'd3, 2'b01, 32'h0,         4'h0,    2'b00, 32'h1,         1'b1};
        tbl[4]  = '{1'b1, 4'd4,  32'h0000_0300, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF,    2'b00, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 4'd4,  32'h0000_0300, 8'd0, 2'b01, 32'h1234_5678, 4'b0101, 2'b00, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 4'd6,  32'h0000_0300, 8'd0, 2'b01, 32'h0,         4'h0,    2'b00, 32'hFF34_FF78, 1'b0};
        tbl[7]  = '{1'b1, 4'd7,  32'h0000_0400, 8'd0, 2'b01, 32'h1111_1111, 4'hF,    2'b00, 32'h0,         1'b0};
        tbl[8]  = '{1'b1, 4'd8,  32'h0000_0400, 8'd0, 2'b10, 32'hAAAA_AAAA, 4'hF,    2'b10, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 4'd9,  32'h0000_0400, 8'd0, 2'b01, 32'h0,         4'h0,    2'b00, 32'h1111_1111, 1'b0};
        tbl[10] = '{1'b0, 4'hA,  32'h0000_0400, 8'd1, 2'b11, 32'h0,         4'h0,    2'b10, 32'h0,         1'b0};
        tbl[11] = '{1'b1, 4'hB,  32'h0000_0500, 8'd2, 2'b00, 32'h7,         4'hF,    2'b00, 32'h0,         1'b0};
        tbl[12] = '{1'b0, 4'hC,  32'h0000_0500, 8'd0, 2'b00, 32'h0,         4'h0,    2'b00, 32'h9,         1'b0};
        tbl[13] = '{1'b0, 4'hD,  32'h0000_0500, 8'd1, 2'b00, 32'h0,         4'h0,    2'b00, 32'h9,         1'b0};
        tbl[14] = '{1'b1, 4'hE,  32'hFFFF_FFFC, 8'd1, 2'b01, 32'h55,        4'hF,    2'b00, 32'h0,         1'b0};
        tbl[15] = '{1'b0, 4'hF,  32'hFFFF_FFFC, 8'd1, 2'b01, 32'h0,         4'h0,    2'b00, 32'h55,        1'b1};
        tbl[16] = '{1'b0, 4'd0,  32'h0000_0000, 8'd0, 2'b01, 32'h0,         4'h0,    2'b00, 32'h56,        1'b0};

        rst = 1'b1;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.rready = 1'b0; axi.bready = 1'b0;
        repeat (3) step();
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_wready", 32'(axi.wready), 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        chk("rst_rid_bid", {axi.rid, axi.bid}, 32'd0);
        chk("rst_resp", {axi.rresp, axi.bresp}, 32'd0);
        chk("rst_ram", {ram_en, ram_we}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_awready", 32'(axi.awready), 32'd1);
        step();

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                aw_issue(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].burst);
                w_beats(tbl[i].addr, tbl[i].burst, tbl[i].d0, tbl[i].strb, int'(tbl[i].len));
                b_wait(br, bi);
                chk($sformatf("v%0d_bresp", i), 32'(br), 32'(tbl[i].resp));
                chk($sformatf("v%0d_bid", i), 32'(bi), 32'(tbl[i].id));
            end else begin
                ar_issue(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].burst);
                read_beats($sformatf("v%0d", i), tbl[i].id, tbl[i].len, tbl[i].exp0, tbl[i].inc, tbl[i].resp);
            end
        end

        // early wlast on the second beat of a four-beat burst
        aw_issue(4'd2, 32'h800, 8'd3, 2'b01);
        w_beats(32'h800, 2'b01, 32'h10, 4'hF, 1);
        b_wait(br, bi);
        chk("early_wlast_bresp", 32'(br), 32'd2);
        chk("early_wlast_bid", 32'(bi), 32'd2);
        ar_issue(4'd1, 32'h800, 8'd1, 2'b01);
        read_beats("early_wlast_rd", 4'd1, 8'd1, 32'h10, 1'b1, 2'b00);

        // simultaneous AW and AR: write must win
        axi.awid = 4'd6; axi.awaddr = 32'h700; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        axi.arid = 4'd7; axi.araddr = 32'h700; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        #1;
        chk("cont_awready", 32'(axi.awready), 32'd1);
        chk("cont_arready", 32'(axi.arready), 32'd0);
        step();
        axi.awvalid = 1'b0;
        #1;
        chk("cont_arready_wr", 32'(axi.arready), 32'd0);
        w_beats(32'h700, 2'b01, 32'hCAFE_F00D, 4'hF, 0);
        b_wait(br, bi);
        chk("cont_bid", 32'(bi), 32'd6);
        ar_issue(4'd7, 32'h700, 8'd0, 2'b01);
        read_beats("cont_rd", 4'd7, 8'd0, 32'hCAFE_F00D, 1'b0, 2'b00);

        // rready held low for five cycles
        axi.rready = 1'b0;
        ar_issue(4'd3, 32'h200, 8'd0, 2'b01);
        n = 0;
        while (!axi.rvalid && n < 20) begin step(); n++; end
        if (n >= 20) chk("bp_timeout", 32'(n), 32'd0);
        held = axi.rdata;
        chk("bp_first", held, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_rvalid", 32'(axi.rvalid), 32'd1);
            chk("bp_rdata", axi.rdata, 32'd1);
            chk("bp_rlast", 32'(axi.rlast), 32'd1);
        end
        axi.rready = 1'b1;
        step();
        chk("bp_release", 32'(axi.rvalid), 32'd0);

        // reset in the middle of a write burst
        aw_issue(4'd9, 32'h900, 8'd3, 2'b01);
        axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        step();
        axi.wvalid = 1'b0;
        rst = 1'b1;
        step();
        chk("rstw_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rstw_wready", 32'(axi.wready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstw_idle_aw", 32'(axi.awready), 32'd1);
        chk("rstw_idle_w", 32'(axi.wready), 32'd0);
        step();

        // reset while a read beat is waiting on rready
        axi.rready = 1'b0;
        ar_issue(4'd4, 32'h200, 8'd3, 2'b01);
        n = 0;
        while (!axi.rvalid && n < 20) begin step(); n++; end
        if (n >= 20) chk("rstr_timeout", 32'(n), 32'd0);
        chk("rstr_pre", 32'(axi.rvalid), 32'd1);
        rst = 1'b1;
        step();
        chk("rstr_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rstr_rlast", 32'(axi.rlast), 32'd0);
        chk("rstr_rdata", axi.rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rstr_idle_ar", 32'(axi.arready), 32'd1);
        step();

        ar_issue(4'd5, 32'h100, 8'd0, 2'b01);
        read_beats("post_rst", 4'd5, 8'd0, 32'hDEAD_BEEF, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
